result_display_scan: RTL

- Downstream consumer of the CPU's 32-bit `result` output. Displays the value as 8 hex digits on a multiplexed, common-anode 7-segment display.
- Holds the displayed value stable for a whole scan frame. A new result is applied only at a frame boundary, so the display never tears mid-frame.
- Runs on the same `clk` as the CPU.

---
 rtl/result_display_scan.sv | 126 ++++++++++++
 1 files changed

// File: rtl/result_display_scan.sv
// Scans a 32-bit result across an 8-digit common-anode 7-segment display.
// A new value is latched into the display only at a frame boundary, so a frame never tears.
module result_display_scan #(
    parameter int SCAN_DIV = 50_000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        result_valid,
    input  logic [31:0] result,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        pending
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [31:0]      shown_q, shown_d;
    logic [31:0]      pend_val_q, pend_val_d;
    logic             pending_q, pending_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             tick;
    logic             fb;
    logic [7:0]       blank;
    logic [3:0]       nibble;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    // Digit 0 always shows, so a zero value still reads "0".
    assign blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_blank
            assign blank[gi] = LZ_BLANK && (shown_q[31:4*gi] == '0);
        end
    endgenerate

    assign tick   = en && (div_cnt_q == DIV_LAST);
    assign fb     = tick && (digit_idx_q == 3'd7);
    assign nibble = shown_q[{digit_idx_q, 2'b00} +: 4];

    always_comb begin
        div_cnt_d   = div_cnt_q;
        digit_idx_d = digit_idx_q;
        shown_d     = shown_q;
        pend_val_d  = pend_val_q;
        pending_d   = pending_q;
        an_d        = 8'hFF;
        seg_d       = 8'hFF;

        if (en) begin
            if (tick) begin
                div_cnt_d   = '0;
                digit_idx_d = digit_idx_q + 3'd1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end

        // A strobe landing on the boundary itself bypasses the pending register.
        if (fb) begin
            if (result_valid) begin
                shown_d = result;
            end else if (pending_q) begin
                shown_d = pend_val_q;
            end
            pending_d = 1'b0;
        end else if (result_valid) begin
            pend_val_d = result;
            pending_d  = 1'b1;
        end

        if (en) begin
            an_d  = ~(8'b1 << digit_idx_q);
            seg_d = blank[digit_idx_q] ? 8'hFF : hex7(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            digit_idx_q <= 3'd0;
            shown_q     <= '0;
            pend_val_q  <= '0;
            pending_q   <= 1'b0;
            an_q        <= 8'hFF;
            seg_q       <= 8'hFF;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            shown_q     <= shown_d;
            pend_val_q  <= pend_val_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign pending = pending_q;

endmodule
